// File: rtl/duration_meter_scheduler.sv
// Time-shared period/high-time meter: scans the enabled channels one at a time
// and keeps the last result of every channel in a register bank with a read port.
module duration_meter_scheduler #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100000000,
  parameter int unsigned AW      = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N_CH-1:0]  enable_mask,
  input  logic [N_CH-1:0]  sig_in,
  output logic             busy,
  output logic             done,
  input  logic [AW-1:0]    rd_addr,
  output logic [CNT_W-1:0] rd_period,
  output logic [CNT_W-1:0] rd_high,
  output logic             rd_valid,
  output logic [N_CH-1:0]  timeout_flags
);

  localparam int unsigned CH_W = $clog2(N_CH);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    ARM,
    MEAS_HIGH,
    MEAS_LOW,
    NEXT,
    DONE
  } state_t;

  state_t            state;
  logic [N_CH-1:0]   sync1;
  logic [N_CH-1:0]   sync2;
  logic [N_CH-1:0]   mask_q;
  logic [N_CH-1:0]   valid;
  logic [CH_W-1:0]   ch;
  logic              prev;
  logic [CNT_W-1:0]  tcnt;
  logic [CNT_W-1:0]  ecnt;
  logic [CNT_W-1:0]  high_q;
  logic [CNT_W-1:0]  bank_period [N_CH];
  logic [CNT_W-1:0]  bank_high   [N_CH];

  logic              sel_c;
  logic              rise_c;
  logic              fall_c;
  logic [CNT_W-1:0]  tcnt_inc_c;
  logic              tmo_c;
  logic [CH_W:0]     first_c;
  logic [CH_W:0]     next_c;

  // Lowest set bit of m at index >= from; MSB of the result flags "found".
  function automatic logic [CH_W:0] pick(input logic [N_CH-1:0] m, input int from);
    logic [CH_W:0] r;
    r = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  assign sel_c      = sync2[ch];
  assign rise_c     = sel_c & ~prev;
  assign fall_c     = ~sel_c & prev;
  assign tcnt_inc_c = tcnt + CNT_W'(1);
  assign tmo_c      = (tcnt_inc_c == CNT_W'(TIMEOUT));
  assign first_c    = pick(enable_mask, 0);
  assign next_c     = pick(mask_q, int'(ch) + 1);

  // Scan sequencer, measurement counters and result bank.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      sync1         <= '0;
      sync2         <= '0;
      mask_q        <= '0;
      valid         <= '0;
      timeout_flags <= '0;
      ch            <= '0;
      prev          <= 1'b0;
      tcnt          <= '0;
      ecnt          <= '0;
      high_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) begin
        bank_period[i] <= '0;
        bank_high[i]   <= '0;
      end
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      prev  <= sel_c;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the finished scan.
          if (start && !done) begin
            mask_q <= enable_mask;
            busy   <= 1'b1;
            if (!first_c[CH_W]) begin
              state <= DONE;
            end else begin
              ch            <= first_c[CH_W-1:0];
              valid         <= valid & ~enable_mask;
              timeout_flags <= timeout_flags & ~enable_mask;
              state         <= SELECT;
            end
          end
        end
        SELECT: begin
          tcnt  <= '0;
          state <= ARM;
        end
        ARM: begin
          tcnt <= tcnt_inc_c;
          if (tmo_c) begin
            timeout_flags[ch] <= 1'b1;
            bank_period[ch]   <= '0;
            bank_high[ch]     <= '0;
            state             <= NEXT;
          end else if (rise_c) begin
            ecnt  <= CNT_W'(1);
            state <= MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          tcnt <= tcnt_inc_c;
          ecnt <= ecnt + CNT_W'(1);
          if (tmo_c) begin
            timeout_flags[ch] <= 1'b1;
            bank_period[ch]   <= '0;
            bank_high[ch]     <= '0;
            state             <= NEXT;
          end else if (fall_c) begin
            high_q <= ecnt;
            state  <= MEAS_LOW;
          end
        end
        MEAS_LOW: begin
          tcnt <= tcnt_inc_c;
          ecnt <= ecnt + CNT_W'(1);
          // Completion takes priority over a timeout in the same cycle.
          if (rise_c) begin
            bank_period[ch] <= ecnt;
            bank_high[ch]   <= high_q;
            valid[ch]       <= 1'b1;
            state           <= NEXT;
          end else if (tmo_c) begin
            timeout_flags[ch] <= 1'b1;
            bank_period[ch]   <= '0;
            bank_high[ch]     <= '0;
            state             <= NEXT;
          end
        end
        NEXT: begin
          if (next_c[CH_W]) begin
            ch    <= next_c[CH_W-1:0];
            state <= SELECT;
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered read port; a same-cycle bank write shows up one cycle later.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_period <= '0;
      rd_high   <= '0;
      rd_valid  <= 1'b0;
    end else if (32'(rd_addr) < N_CH) begin
      rd_period <= bank_period[CH_W'(rd_addr)];
      rd_high   <= bank_high[CH_W'(rd_addr)];
      rd_valid  <= valid[CH_W'(rd_addr)];
    end else begin
      rd_period <= '0;
      rd_high   <= '0;
      rd_valid  <= 1'b0;
    end
  end

endmodule
